// File: rtl/bridge_io.sv
// bridge_io: address decode between the CPU MEM-stage bus and DRAM / on-chip I/O.
// Owns the LED register, synchronised switch and button inputs, a prescaled
// free-running timer and an 8-digit multiplexed 7-segment display driver.
//
// Bus protocol: there is no valid/ready handshake. The bridge is always ready;
// every cycle carries one access. Bus_wen=1 marks a write that commits on the
// next rising edge, Bus_wen=0 is a read whose data is returned combinationally
// in the same cycle on Bus_rdata.
module bridge_io #(
  parameter int SCAN_DIV  = 20000,
  parameter int TIMER_DIV = 25000,
  parameter int DRAM_AW   = 14
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        Bus_addr,
  output logic [31:0]        Bus_rdata,
  input  logic               Bus_wen,
  input  logic [31:0]        Bus_wdata,
  output logic [DRAM_AW-1:0] dram_addr,
  input  logic [31:0]        dram_rdata,
  output logic               dram_wen,
  output logic [31:0]        dram_wdata,
  input  logic [23:0]        sw,
  input  logic [4:0]         btn,
  output logic [23:0]        led,
  output logic [7:0]         dig_en,
  output logic [7:0]         dig_seg
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int TIMER_W = $clog2(TIMER_DIV);

  localparam logic [11:0] OFF_DIG   = 12'h000;
  localparam logic [11:0] OFF_TIMER = 12'h020;
  localparam logic [11:0] OFF_LED   = 12'h060;
  localparam logic [11:0] OFF_SW    = 12'h070;
  localparam logic [11:0] OFF_BTN   = 12'h078;

  logic               is_io;
  logic [11:0]        io_off;
  logic               io_wen;
  logic               wen_dig;
  logic               wen_timer;
  logic               wen_led;

  logic [31:0]        dig_q;
  logic [23:0]        led_q;
  logic [23:0]        sw_s1;
  logic [23:0]        sw_s2;
  logic [4:0]         btn_s1;
  logic [4:0]         btn_s2;
  logic [31:0]        timer_q;
  logic [TIMER_W-1:0] presc_q;
  logic [SCAN_W-1:0]  scan_q;
  logic [2:0]         idx_q;
  logic [31:0]        io_rdata;

  // Hex nibble to active-low segment pattern {DP,G,F,E,D,C,B,A}, DP off.
  function automatic logic [7:0] hex7(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // The top 4 KiB page of the address space is I/O; everything else is DRAM.
  assign is_io     = (Bus_addr[31:12] == 20'hFFFFF);
  assign io_off    = Bus_addr[11:0];
  assign io_wen    = Bus_wen & is_io;
  assign wen_dig   = io_wen && (io_off == OFF_DIG);
  assign wen_timer = io_wen && (io_off == OFF_TIMER);
  assign wen_led   = io_wen && (io_off == OFF_LED);

  // DRAM side is a pure pass-through, reset has no effect on it.
  assign dram_addr  = Bus_addr[DRAM_AW+1:2];
  assign dram_wdata = Bus_wdata;
  assign dram_wen   = Bus_wen & ~is_io;
  assign led        = led_q;

  // Combinational I/O read mux; unmapped offsets read as zero.
  always_comb begin
    io_rdata = 32'h0;
    case (io_off)
      OFF_DIG:   io_rdata = dig_q;
      OFF_TIMER: io_rdata = timer_q;
      OFF_LED:   io_rdata = {8'h0, led_q};
      OFF_SW:    io_rdata = {8'h0, sw_s2};
      OFF_BTN:   io_rdata = {27'h0, btn_s2};
      default:   io_rdata = 32'h0;
    endcase
  end

  // Final read data select between DRAM and I/O, same-cycle for the MEM/WB latch.
  always_comb begin
    Bus_rdata = dram_rdata;
    if (is_io) Bus_rdata = io_rdata;
  end

  // Two-flop synchronisers for the asynchronous switch and button pins.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      sw_s1  <= 24'h0;
      sw_s2  <= 24'h0;
      btn_s1 <= 5'h0;
      btn_s2 <= 5'h0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
    end
  end

  // CPU-writable display and LED registers.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      dig_q <= 32'h0;
      led_q <= 24'h0;
    end else begin
      if (wen_dig) dig_q <= Bus_wdata;
      if (wen_led) led_q <= Bus_wdata[23:0];
    end
  end

  // Timer: prescaler wraps every TIMER_DIV cycles and bumps the count;
  // a CPU load overrides a coincident tick and restarts the prescaler.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      timer_q <= 32'h0;
      presc_q <= '0;
    end else if (wen_timer) begin
      timer_q <= Bus_wdata;
      presc_q <= '0;
    end else if (presc_q == TIMER_W'(TIMER_DIV - 1)) begin
      timer_q <= timer_q + 32'd1;
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + TIMER_W'(1);
    end
  end

  // Scan counter: each digit slot lasts SCAN_DIV cycles, idx cycles 0..7.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      scan_q <= '0;
      idx_q  <= 3'd0;
    end else if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_q <= '0;
      idx_q  <= idx_q + 3'd1;
    end else begin
      scan_q <= scan_q + SCAN_W'(1);
    end
  end

  // Registered digit drive from the current idx; blank while in reset.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      dig_en  <= 8'hFF;
      dig_seg <= 8'hFF;
    end else begin
      dig_en  <= ~(8'h01 << idx_q);
      dig_seg <= hex7(dig_q[{idx_q, 2'b00} +: 4]);
    end
  end

endmodule
